sys_ctrl: RTL and testbench

SYS_CTRL -- requirements
Module: sys_ctrl

---
 rtl/sys_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sys_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// UART command controller: decodes RF write/read and ALU frames and queues response bytes to the TX FIFO.
// Optional macro SYS_CTRL_ERR_RESP_EN: unknown IDLE commands answer with a single 0xEE byte instead of being dropped.
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                      CLK,
    input  logic                      RST_n,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]     RF_Address,
    output logic                      RF_WrEn,
    output logic                      RF_RdEn,
    output logic [DATA_WIDTH-1:0]     RF_WrData,
    input  logic [DATA_WIDTH-1:0]     RF_RdData,
    input  logic                      RF_RdData_Valid,
    output logic                      ALU_EN,
    output logic [FUN_WIDTH-1:0]      ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    output logic                      CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    input  logic                      FIFO_FULL
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_ADDR  = 4'd1;
    localparam logic [3:0] S_WR_DATA  = 4'd2;
    localparam logic [3:0] S_RD_ADDR  = 4'd3;
    localparam logic [3:0] S_RD_WAIT  = 4'd4;
    localparam logic [3:0] S_OP_A     = 4'd5;
    localparam logic [3:0] S_OP_B     = 4'd6;
    localparam logic [3:0] S_ALU_FUN  = 4'd7;
    localparam logic [3:0] S_ALU_WAIT = 4'd8;
    localparam logic [3:0] S_TX_BYTE0 = 4'd9;
    localparam logic [3:0] S_TX_BYTE1 = 4'd10;

    localparam logic [DATA_WIDTH-1:0] CMD_RF_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RF_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);
`ifdef SYS_CTRL_ERR_RESP_EN
    localparam logic [DATA_WIDTH-1:0] ERR_BYTE    = DATA_WIDTH'(8'hEE);
`endif

    logic [3:0]            state_r;
    logic [DATA_WIDTH-1:0] byte0_r;
    logic [DATA_WIDTH-1:0] byte1_r;
    logic                  two_bytes_r;

    // Frame sequencer; every output is a register, strobes default low each cycle.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_r     <= S_IDLE;
            byte0_r     <= '0;
            byte1_r     <= '0;
            two_bytes_r <= 1'b0;
            RF_Address  <= '0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_WrData   <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            ALU_EN      <= 1'b0;
            TX_D_VLD    <= 1'b0;
            CLK_GATE_EN <= (state_r == S_ALU_FUN) || (state_r == S_ALU_WAIT);
            case (state_r)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            CMD_RF_WR:   state_r <= S_WR_ADDR;
                            CMD_RF_RD:   state_r <= S_RD_ADDR;
                            CMD_ALU_OP:  state_r <= S_OP_A;
                            CMD_ALU_NOP: state_r <= S_ALU_FUN;
                            default: begin
`ifdef SYS_CTRL_ERR_RESP_EN
                                byte0_r     <= ERR_BYTE;
                                two_bytes_r <= 1'b0;
                                state_r     <= S_TX_BYTE0;
`else
                                state_r     <= S_IDLE;
`endif
                            end
                        endcase
                    end
                end
                S_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        state_r    <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WrData <= RX_P_DATA;
                        RF_WrEn   <= 1'b1;
                        state_r   <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        RF_RdEn    <= 1'b1;
                        state_r    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (RF_RdData_Valid) begin
                        byte0_r     <= RF_RdData;
                        two_bytes_r <= 1'b0;
                        state_r     <= S_TX_BYTE0;
                    end
                end
                // Operands land in the fixed ALU source registers 0 and 1.
                S_OP_A: begin
                    if (RX_D_VLD) begin
                        RF_Address <= ADDR_WIDTH'(1'b0);
                        RF_WrData  <= RX_P_DATA;
                        RF_WrEn    <= 1'b1;
                        state_r    <= S_OP_B;
                    end
                end
                S_OP_B: begin
                    if (RX_D_VLD) begin
                        RF_Address <= ADDR_WIDTH'(1'b1);
                        RF_WrData  <= RX_P_DATA;
                        RF_WrEn    <= 1'b1;
                        state_r    <= S_ALU_FUN;
                    end
                end
                S_ALU_FUN: begin
                    if (RX_D_VLD) begin
                        ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                        ALU_EN  <= 1'b1;
                        state_r <= S_ALU_WAIT;
                    end
                end
                S_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        byte0_r     <= ALU_OUT[DATA_WIDTH-1:0];
                        byte1_r     <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                        two_bytes_r <= 1'b1;
                        state_r     <= S_TX_BYTE0;
                    end
                end
                // A full FIFO stalls the push; TX_P_DATA keeps the previous byte meanwhile.
                S_TX_BYTE0: begin
                    if (!FIFO_FULL) begin
                        TX_P_DATA <= byte0_r;
                        TX_D_VLD  <= 1'b1;
                        state_r   <= two_bytes_r ? S_TX_BYTE1 : S_IDLE;
                    end
                end
                S_TX_BYTE1: begin
                    if (!FIFO_FULL) begin
                        TX_P_DATA <= byte1_r;
                        TX_D_VLD  <= 1'b1;
                        state_r   <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: expected strobe events are queued as frames are driven and checked as they appear.
module tb_sys_ctrl;
    logic        CLK = 1'b0;
    logic        RST_n;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [3:0]  RF_Address;
    logic        RF_WrEn;
    logic        RF_RdEn;
    logic [7:0]  RF_WrData;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_Valid;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        FIFO_FULL;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_WrData(RF_WrData),
        .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL)
    );

    always #5 CLK = ~CLK;

    // Event encoding: kind 1 RF write(addr,data), 2 RF read(addr), 3 ALU start(fun), 4 TX push(data).
    function automatic logic [31:0] ev(input logic [7:0] kind, input logic [7:0] a, input logic [7:0] b);
        return {8'd0, kind, a, b};
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic see_event(input logic [31:0] obs, input string tag);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s unexpected observed=%h expected=none", tag, obs);
        end else begin
            chk(obs, exp_q.pop_front(), tag);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_for(input int which, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            case (which)
                0:       seen = RF_RdEn;
                1:       seen = ALU_EN;
                default: seen = 1'b0;
            endcase
        end
        checks++;
        assert (seen) else begin
            failures++;
            $error("FAIL %s timeout observed=none expected=strobe", tag);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({3'd0, RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN,
             CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 32'd0, tag);
    endtask

    // Strobe monitor: every observed strobe must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (RST_n) begin
            chk({31'd0, RF_WrEn & RF_RdEn}, 32'd0, "wr_rd_excl");
            if (RF_WrEn)  see_event(ev(8'd1, {4'd0, RF_Address}, RF_WrData), "rf_wr");
            if (RF_RdEn)  see_event(ev(8'd2, {4'd0, RF_Address}, 8'd0), "rf_rd");
            if (ALU_EN)   see_event(ev(8'd3, {4'd0, ALU_FUN}, 8'd0), "alu_en");
            if (TX_D_VLD) see_event(ev(8'd4, TX_P_DATA, 8'd0), "tx_push");
        end
    end

    initial begin
        RST_n = 1'b0; RX_P_DATA = 8'd0; RX_D_VLD = 1'b0;
        RF_RdData = 8'd0; RF_RdData_Valid = 1'b0;
        ALU_OUT = 16'd0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_n = 1'b1;
        chk_reset_vals("reset_values");

        // RF write frame
        exp_q.push_back(ev(8'd1, 8'h05, 8'h3C));
        send(8'hAA); send(8'h05); send(8'h3C);
        idle(4);

        // RF read frame; a byte arriving in RD_WAIT must be dropped
        exp_q.push_back(ev(8'd2, 8'h07, 8'h00));
        exp_q.push_back(ev(8'd4, 8'h46, 8'h00));
        send(8'hBB); send(8'h07);
        wait_for(0, "rd_en_wait");
        send(8'hAA);
        @(posedge CLK); #1 RF_RdData = 8'h46; RF_RdData_Valid = 1'b1;
        @(posedge CLK); #1 RF_RdData_Valid = 1'b0;
        idle(5);

        // ALU frame with operands
        exp_q.push_back(ev(8'd1, 8'h00, 8'h0A));
        exp_q.push_back(ev(8'd1, 8'h01, 8'h03));
        exp_q.push_back(ev(8'd3, 8'h00, 8'h00));
        exp_q.push_back(ev(8'd4, 8'h0D, 8'h00));
        exp_q.push_back(ev(8'd4, 8'h00, 8'h00));
        send(8'hCC); send(8'h0A); send(8'h03); send(8'h00);
        wait_for(1, "alu_en_wait_cc");
        chk({31'd0, CLK_GATE_EN}, 32'd1, "clk_gate_on");
        send(8'hBB);
        chk({31'd0, CLK_GATE_EN}, 32'd1, "clk_gate_held");
        @(posedge CLK); #1 ALU_OUT = 16'h000D; ALU_OUT_VLD = 1'b1;
        @(posedge CLK); #1 ALU_OUT_VLD = 1'b0;
        @(posedge CLK); #1;
        chk({31'd0, CLK_GATE_EN}, 32'd0, "clk_gate_off");
        idle(5);

        // ALU frame without operands, TX FIFO full for 5 cycles
        FIFO_FULL = 1'b1;
        exp_q.push_back(ev(8'd3, 8'h02, 8'h00));
        exp_q.push_back(ev(8'd4, 8'h34, 8'h00));
        exp_q.push_back(ev(8'd4, 8'h12, 8'h00));
        send(8'hDD); send(8'h02);
        wait_for(1, "alu_en_wait_dd");
        @(posedge CLK); #1 ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
        @(posedge CLK); #1 ALU_OUT_VLD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk({31'd0, TX_D_VLD}, 32'd0, "tx_withheld");
            chk({24'd0, TX_P_DATA}, 32'h00, "tx_data_stable");
        end
        @(posedge CLK); #1 FIFO_FULL = 1'b0;
        idle(6);

        // Reset in the middle of an RF write frame
        send(8'hAA); send(8'h05);
        @(posedge CLK); #1 RST_n = 1'b0;
        @(posedge CLK); #1 RST_n = 1'b1;
        chk_reset_vals("midframe_reset");
`ifdef SYS_CTRL_ERR_RESP_EN
        exp_q.push_back(ev(8'd4, 8'hEE, 8'h00));
`endif
        send(8'h3C);
        idle(6);
        exp_q.push_back(ev(8'd1, 8'h05, 8'h3C));
        send(8'hAA); send(8'h05); send(8'h3C);
        idle(4);

        // Unknown command byte
`ifdef SYS_CTRL_ERR_RESP_EN
        exp_q.push_back(ev(8'd4, 8'hEE, 8'h00));
`endif
        send(8'h55);
        idle(6);

        chk(exp_q.size(), 32'd0, "scoreboard_drained");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
